// File: rtl/hilo_mdu_ctrl.sv
// EX-stage HI/LO owner and mul/div launch sequencer; result lands one cycle after unit latency, holds EX via stall_req_o.
// Optional HILO_FWD_EN: hi_o/lo_o forward the value being written this cycle instead of the registered copy.
module hilo_mdu_ctrl #(
  parameter logic [31:0] HILO_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        ex_valid_i,
  input  logic [2:0]  ex_op_i,
  input  logic [31:0] ex_rs_i,
  input  logic [31:0] ex_rt_i,
  output logic        stall_req_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        md_start_o,
  output logic        md_annul_o,
  output logic        md_signed_o,
  output logic [1:0]  md_sel_o,
  output logic [31:0] md_op1_o,
  output logic [31:0] md_op2_o,
  input  logic [63:0] md_result_i,
  input  logic        md_ready_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        mdop;
  logic        launch;
  logic        wr_md;
  logic        wr_hi;
  logic        wr_lo;

  assign mdop   = ex_valid_i && (ex_op_i != 3'd0) && (ex_op_i <= 3'd4);
  assign launch = (state == S_IDLE) && mdop && !flush_i;
  assign wr_md  = (state == S_WAIT) && md_ready_i && !flush_i;
  assign wr_hi  = (state == S_IDLE) && ex_valid_i && (ex_op_i == 3'd5) && !flush_i;
  assign wr_lo  = (state == S_IDLE) && ex_valid_i && (ex_op_i == 3'd6) && !flush_i;

  // Stall drops in the ready cycle so the HI/LO write and the EX advance share one edge.
  assign stall_req_o = launch || ((state == S_WAIT) && !md_ready_i && !flush_i);
  assign md_annul_o  = flush_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      hi_q        <= HILO_RST;
      lo_q        <= HILO_RST;
      md_start_o  <= 1'b0;
      md_signed_o <= 1'b0;
      md_sel_o    <= 2'b00;
      md_op1_o    <= 32'h0;
      md_op2_o    <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (launch) begin
            md_op1_o    <= ex_rs_i;
            md_op2_o    <= ex_rt_i;
            md_signed_o <= (ex_op_i == 3'd1) || (ex_op_i == 3'd3);
            md_sel_o    <= (ex_op_i <= 3'd2) ? 2'b01 : 2'b10;
            md_start_o  <= 1'b1;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (flush_i) begin
            md_start_o <= 1'b0;
            md_sel_o   <= 2'b00;
            state      <= S_IDLE;
          end else if (md_ready_i) begin
            md_start_o <= 1'b0;
            state      <= S_DONE;
          end
        end
        // One cycle with start low lets the unit return to its free state before a relaunch.
        S_DONE: begin
          md_start_o <= 1'b0;
          md_sel_o   <= 2'b00;
          state      <= S_IDLE;
        end
        default: begin
          md_start_o <= 1'b0;
          md_sel_o   <= 2'b00;
          state      <= S_IDLE;
        end
      endcase

      if (wr_md) begin
        hi_q <= md_result_i[63:32];
        lo_q <= md_result_i[31:0];
      end else begin
        if (wr_hi) hi_q <= ex_rs_i;
        if (wr_lo) lo_q <= ex_rs_i;
      end
    end
  end

`ifdef HILO_FWD_EN
  assign hi_o = wr_md ? md_result_i[63:32] : (wr_hi ? ex_rs_i : hi_q);
  assign lo_o = wr_md ? md_result_i[31:0]  : (wr_lo ? ex_rs_i : lo_q);
`else
  assign hi_o = hi_q;
  assign lo_o = lo_q;
`endif

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Bench for hilo_mdu_ctrl: vector table, hand-written flush/reset sequences and random ops against a HI/LO model.
module tb_hilo_mdu_ctrl;

  localparam logic [31:0] HR = 32'hDEAD_BEEF;
`ifdef HILO_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        ex_valid_i;
  logic [2:0]  ex_op_i;
  logic [31:0] ex_rs_i;
  logic [31:0] ex_rt_i;
  logic        stall_req_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        md_start_o;
  logic        md_annul_o;
  logic        md_signed_o;
  logic [1:0]  md_sel_o;
  logic [31:0] md_op1_o;
  logic [31:0] md_op2_o;
  logic [63:0] md_result_i;
  logic        md_ready_i;

  int n_cmp = 0;
  int n_err = 0;
  int unit_lat = 1;
  int unit_cnt = 0;
  logic [31:0] ref_hi;
  logic [31:0] ref_lo;

  always #5 clk = ~clk;

  hilo_mdu_ctrl #(.HILO_RST(HR)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .ex_valid_i(ex_valid_i), .ex_op_i(ex_op_i),
    .ex_rs_i(ex_rs_i), .ex_rt_i(ex_rt_i), .stall_req_o(stall_req_o), .hi_o(hi_o), .lo_o(lo_o),
    .md_start_o(md_start_o), .md_annul_o(md_annul_o), .md_signed_o(md_signed_o),
    .md_sel_o(md_sel_o), .md_op1_o(md_op1_o), .md_op2_o(md_op2_o),
    .md_result_i(md_result_i), .md_ready_i(md_ready_i)
  );

  // Architectural result of a mul/div: {HI, LO}; divide is {remainder, quotient}, divide by zero yields 0.
  function automatic logic [63:0] calc(input bit mul, input bit sgn, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic signed [31:0] x, y, q, rm;
    if (mul) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      if (sgn) return sa * sb;
      return {32'h0, a} * {32'h0, b};
    end
    if (b == 32'h0) return 64'h0;
    if (sgn) begin
      x = a; y = b;
      q = x / y; rm = x % y;
      return {rm, q};
    end
    return {a % b, a / b};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Iterative unit stand-in: raises ready after start has been seen high for unit_lat cycles.
  always begin
    @(posedge clk);
    #1;
    if (rst || !md_start_o) begin
      unit_cnt = 0;
      md_ready_i = 1'b0;
      md_result_i = {$urandom, $urandom};
    end else if (!md_ready_i) begin
      unit_cnt++;
      if (unit_cnt >= unit_lat) begin
        md_ready_i = 1'b1;
        md_result_i = calc(md_sel_o == 2'b01, md_signed_o, md_op1_o, md_op2_o);
      end else begin
        md_result_i = {$urandom, $urandom};
      end
    end
  end

  // Entered and left at posedge+1 with EX idle.
  task automatic run_op(input logic vld, input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input int lat, input logic [2:0] done_op);
    bit md;
    logic [63:0] exp;
    int n;
    md = vld && (op inside {[3'd1:3'd4]});
    exp = {ref_hi, ref_lo};
    if (md) exp = calc(op <= 3'd2, (op == 3'd1) || (op == 3'd3), rs, rt);
    else if (vld && op == 3'd5) exp[63:32] = rs;
    else if (vld && op == 3'd6) exp[31:0] = rs;
    unit_lat = lat;
    ex_valid_i = vld; ex_op_i = op; ex_rs_i = rs; ex_rt_i = rt;
    @(negedge clk);
    if (md) begin
      chk("launch_stall", 64'(stall_req_o), 64'd1);
      n = 0;
      while (stall_req_o && n < 200) begin
        n++;
        @(negedge clk);
      end
      chk("stall_cycles", 64'(n), 64'(lat));
      chk("ready_start", 64'(md_start_o), 64'd1);
      chk("ready_sel", 64'(md_sel_o), (op <= 3'd2) ? 64'd1 : 64'd2);
      chk("ready_signed", 64'(md_signed_o), 64'((op == 3'd1) || (op == 3'd3)));
      chk("ready_hilo", {hi_o, lo_o}, FWD ? exp : {ref_hi, ref_lo});
      @(posedge clk); #1;
      ex_valid_i = (done_op != 3'd0); ex_op_i = done_op; ex_rs_i = 32'h0BAD_0BAD; ex_rt_i = 32'd5;
      @(negedge clk);
      chk("done_stall", 64'(stall_req_o), 64'd0);
      chk("done_start", 64'(md_start_o), 64'd0);
      chk("done_hilo", {hi_o, lo_o}, exp);
    end else begin
      chk("nomd_stall", 64'(stall_req_o), 64'd0);
      chk("nomd_hilo", {hi_o, lo_o}, FWD ? exp : {ref_hi, ref_lo});
    end
    @(posedge clk); #1;
    ex_valid_i = 1'b0; ex_op_i = 3'd0;
    @(negedge clk);
    chk("hilo", {hi_o, lo_o}, exp);
    chk("idle_start", 64'(md_start_o), 64'd0);
    ref_hi = exp[63:32]; ref_lo = exp[31:0];
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        vld;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    int          lat;
    logic [2:0]  done_op;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t tbl[11];

  initial begin
    logic [63:0] save;
    logic [2:0]  rop;
    logic [31:0] rrs, rrt;

    tbl[0]  = '{1'b1, 3'd1, 32'hFFFF_FFF9, 32'd3,         4, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    tbl[1]  = '{1'b1, 3'd4, 32'd100,       32'd7,         3, 3'd0, 32'd2,         32'd14};
    tbl[2]  = '{1'b1, 3'd3, 32'hFFFF_FFF9, 32'd2,         5, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[3]  = '{1'b1, 3'd3, 32'd5,         32'd0,         2, 3'd0, 32'h0,         32'h0};
    tbl[4]  = '{1'b1, 3'd5, 32'h1234_5678, 32'd9,         1, 3'd0, 32'h1234_5678, 32'h0};
    tbl[5]  = '{1'b1, 3'd6, 32'h9ABC_DEF0, 32'd9,         1, 3'd0, 32'h1234_5678, 32'h9ABC_DEF0};
    tbl[6]  = '{1'b1, 3'd7, 32'h1,         32'd1,         1, 3'd0, 32'h1234_5678, 32'h9ABC_DEF0};
    tbl[7]  = '{1'b1, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 3'd5, 32'hFFFF_FFFE, 32'h0000_0001};
    tbl[8]  = '{1'b1, 3'd0, 32'h55,        32'd3,         1, 3'd0, 32'hFFFF_FFFE, 32'h0000_0001};
    tbl[9]  = '{1'b1, 3'd1, 32'h8000_0000, 32'd2,         6, 3'd4, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[10] = '{1'b0, 3'd1, 32'd3,         32'd3,         1, 3'd0, 32'hFFFF_FFFF, 32'h0000_0000};

    rst = 1'b1; flush_i = 1'b0; ex_valid_i = 1'b0; ex_op_i = 3'd0; ex_rs_i = 32'h0; ex_rt_i = 32'h0;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    chk("rst_hilo", {hi_o, lo_o}, {HR, HR});
    chk("rst_start", 64'(md_start_o), 64'd0);
    chk("rst_sel_signed", 64'({md_sel_o, md_signed_o}), 64'd0);
    chk("rst_ops", {md_op1_o, md_op2_o}, 64'd0);
    chk("rst_stall", 64'(stall_req_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    ref_hi = HR; ref_lo = HR;

    for (int i = 0; i < 11; i++) begin
      run_op(tbl[i].vld, tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].lat, tbl[i].done_op);
      chk($sformatf("vec%0d_hilo", i), {hi_o, lo_o}, {tbl[i].exp_hi, tbl[i].exp_lo});
    end

    // Flush on WAIT cycle 10 of a long divide, then a clean MULTU.
    save = {ref_hi, ref_lo};
    unit_lat = 30;
    ex_valid_i = 1'b1; ex_op_i = 3'd3; ex_rs_i = 32'd1000; ex_rt_i = 32'd3;
    @(negedge clk);
    chk("fl_launch_stall", 64'(stall_req_o), 64'd1);
    repeat (10) @(posedge clk);
    #1; flush_i = 1'b1;
    @(negedge clk);
    chk("fl_annul", 64'(md_annul_o), 64'd1);
    chk("fl_stall", 64'(stall_req_o), 64'd0);
    @(posedge clk); #1;
    flush_i = 1'b0; ex_valid_i = 1'b0;
    @(negedge clk);
    chk("fl_start", 64'(md_start_o), 64'd0);
    chk("fl_sel", 64'(md_sel_o), 64'd0);
    chk("fl_stall_after", 64'(stall_req_o), 64'd0);
    chk("fl_hilo", {hi_o, lo_o}, save);
    @(posedge clk); #1;
    run_op(1'b1, 3'd2, 32'd6, 32'd7, 3, 3'd0);
    chk("fl_multu_42", {hi_o, lo_o}, 64'd42);

    // Flush coinciding with ready: no write.
    save = {ref_hi, ref_lo};
    unit_lat = 3;
    ex_valid_i = 1'b1; ex_op_i = 3'd4; ex_rs_i = 32'd50; ex_rt_i = 32'd5;
    repeat (3) @(posedge clk);
    #1; flush_i = 1'b1;
    @(negedge clk);
    chk("flr_stall", 64'(stall_req_o), 64'd0);
    chk("flr_fwd", {hi_o, lo_o}, save);
    @(posedge clk); #1;
    flush_i = 1'b0; ex_valid_i = 1'b0;
    @(negedge clk);
    chk("flr_hilo", {hi_o, lo_o}, save);
    chk("flr_start", 64'(md_start_o), 64'd0);
    @(posedge clk); #1;

    // Flush in IDLE suppresses MTHI and a launch.
    flush_i = 1'b1; ex_valid_i = 1'b1; ex_op_i = 3'd5; ex_rs_i = 32'h0000_FEED;
    @(negedge clk);
    chk("fli_annul", 64'(md_annul_o), 64'd1);
    chk("fli_hilo", {hi_o, lo_o}, save);
    @(posedge clk); #1;
    ex_op_i = 3'd3; ex_rt_i = 32'd4;
    @(negedge clk);
    chk("fli_md_stall", 64'(stall_req_o), 64'd0);
    @(posedge clk); #1;
    flush_i = 1'b0; ex_valid_i = 1'b0;
    @(negedge clk);
    chk("fli_start", 64'(md_start_o), 64'd0);
    chk("fli_hilo2", {hi_o, lo_o}, save);
    @(posedge clk); #1;

    // Reset in the middle of a multiply.
    unit_lat = 20;
    ex_valid_i = 1'b1; ex_op_i = 3'd1; ex_rs_i = 32'd77; ex_rt_i = 32'd11;
    repeat (5) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; ex_valid_i = 1'b0;
    @(negedge clk);
    chk("mrst_hilo", {hi_o, lo_o}, {HR, HR});
    chk("mrst_ctl", 64'({stall_req_o, md_start_o, md_signed_o, md_sel_o}), 64'd0);
    chk("mrst_ops", {md_op1_o, md_op2_o}, 64'd0);
    ref_hi = HR; ref_lo = HR;
    @(posedge clk); #1;

    for (int i = 0; i < 80; i++) begin
      rop = 3'($urandom_range(0, 7));
      rrs = $urandom;
      if ($urandom_range(0, 9) == 0) rrt = 32'h0;
      else if ($urandom_range(0, 3) == 0) rrt = 32'($urandom_range(1, 20));
      else rrt = $urandom;
      if (rop == 3'd3 && rrs == 32'h8000_0000 && rrt == 32'hFFFF_FFFF) rrt = 32'd1;
      run_op($urandom_range(0, 7) != 0, rop, rrs, rrt, $urandom_range(1, 6), 3'($urandom_range(0, 6)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hilo_mdu_ctrl.md
Name: hilo_mdu_ctrl

Overview:
- EX-stage sequencer sitting directly upstream of the iterative multiply/divide unit.
- Decodes MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX, launches the unit (start, sel, signed, operands) and holds the pipeline via a stall request until the unit reports ready.
- Writes the 64-bit result into the architectural HI/LO registers, then releases the unit with start low.
- Owns HI/LO and supplies them to MFHI/MFLO.

Parameters:
- HILO_RST, 32'h0000_0000, reset value of both HI and LO.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush_i  in  1  pipeline flush; kills the in-flight op
- ex_valid_i  in  1  EX instruction valid
- ex_op_i  in  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
- ex_rs_i  in  32  rs operand (dividend / multiplicand / MTHI-MTLO data)
- ex_rt_i  in  32  rt operand (divisor / multiplier)
- stall_req_o  out  1  hold IF/ID/EX
- hi_o  out  32  HI value
- lo_o  out  32  LO value
- md_start_o  out  1  unit start (registered)
- md_annul_o  out  1  unit annul
- md_signed_o  out  1  1 for MULT/DIV
- md_sel_o  out  2  01 multiply, 10 divide, 00 idle
- md_op1_o  out  32  latched rs
- md_op2_o  out  32  latched rt
- md_result_i  in  64  unit result: {HI, LO}; for divide {remainder, quotient}
- md_ready_i  in  1  unit result valid

Behaviour:
- Reset: state IDLE; HI=LO=HILO_RST; md_start_o, md_signed_o=0; md_sel_o=00; md_op1_o, md_op2_o=0.
- md_annul_o = flush_i, combinational.
- mdop = ex_valid_i and ex_op_i in 1..4.
- States: IDLE, WAIT, DONE.
- IDLE:
  - mdop and !flush_i: stall_req_o=1 (combinational, same cycle). At the next edge, latch md_op1_o/md_op2_o from rs/rt, md_signed_o = (op is MULT or DIV), md_sel_o (01 for op 1/2, 10 for op 3/4), md_start_o<=1, go to WAIT.
  - ex_valid_i and op 5 or 6 and !flush_i: HI (op 5) or LO (op 6) <= ex_rs_i at the edge. No stall.
  - Otherwise: no action, stall_req_o=0.
- WAIT:
  - stall_req_o=1 while !md_ready_i.
  - md_ready_i=1 and !flush_i: HI<=md_result_i[63:32], LO<=md_result_i[31:0], md_start_o<=0, go to DONE. stall_req_o=0 in the ready cycle, so the write and the EX advance coincide.
- DONE:
  - stall_req_o=0, md_start_o=0, single cycle, then IDLE.
  - Guarantees the unit sees start low and returns to its free state before any relaunch.
  - Any EX op present in DONE is ignored.
- flush_i:
  - In WAIT or DONE: next state IDLE, md_start_o<=0, md_sel_o<=00, no HI/LO write, stall_req_o=0.
  - In IDLE: suppresses launch and MTHI/MTLO.
  - flush_i together with md_ready_i: flush wins, no write.
- Result latency = unit latency + 1 cycle (launch register); the unit signals divide-by-zero via a zero result, which is written unchanged.
- Back-to-back md ops: minimum two-cycle gap (DONE + IDLE launch cycle) between unit releases.
- Reset mid-operation: immediate return to reset values. The unit is reset by the same rst.
- hi_o/lo_o are the registered values (see Optional Feature).

Optional Feature:
- Macro: HILO_FWD_EN.
- Defined:
  - hi_o/lo_o combinationally forward the value being written this cycle, so an MFHI/MFLO reading concurrently sees the new value.
  - Sources: md_result_i halves in the WAIT ready cycle; ex_rs_i for MTHI/MTLO.
- Undefined: hi_o/lo_o are pure register outputs, updated the cycle after the write.

Test Plan:
- MULT rs=0xFFFFFFF9 (-7), rt=3 -> stall held until ready; then HI=0xFFFFFFFF, LO=0xFFFFFFEB; md_sel_o=01, md_signed_o=1.
- DIVU rs=100, rt=7 -> HI=2, LO=14; md_start_o low in DONE; stall drops in the ready cycle.
- DIV rs=0xFFFFFFF9, rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV rt=0 -> HI=LO=0, no hang.
- MTHI rs=0x12345678 in IDLE -> HI=0x12345678 the next cycle, stall_req_o never asserted. With HILO_FWD_EN, hi_o=0x12345678 in the same cycle.
- Launch DIV, assert flush_i on WAIT cycle 10 -> md_annul_o=1 that cycle, state IDLE, HI/LO unchanged, stall released; a new MULTU 6x7 afterwards gives LO=42, HI=0.
- Assert rst during WAIT -> all outputs at reset values next cycle, HI=LO=HILO_RST.
